// File: rtl/e_mdu_pkg.sv
// e_mdu shared definitions: MDU op codes, default latencies, FSM states.
// Also used by the D-stage decoder and the hazard unit.
package e_mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;
    localparam int MDU_CNT_W       = 16;

    function automatic logic mdu_is_start_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    function automatic logic mdu_is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit with fixed-latency HI/LO commit.
// Result is computed at start into a shadow and committed when the count expires.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDUOp,
    input  logic        E_Start,
    input  logic [31:0] E_RS,
    input  logic [31:0] E_RT,
    output logic        E_Busy,
    output logic [31:0] E_MDUOut,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);

    localparam logic [MDU_CNT_W-1:0] MULT_CNT = MDU_CNT_W'(MULT_CYCLES);
    localparam logic [MDU_CNT_W-1:0] DIV_CNT  = MDU_CNT_W'(DIV_CYCLES);

    mdu_state_e            state_q, state_d;
    logic [MDU_CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]           hi_q, hi_d, lo_q, lo_d;
    logic [31:0]           sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
    logic                  commit_q, commit_d;

    logic [63:0]           prod_s, prod_u, res;
    logic signed [31:0]    rs_s, rt_s, quo_s, rem_s;
    logic [31:0]           rt_u, quo_u, rem_u;
    logic                  rt_zero, div_ovf;

    // Full 64-bit {hi,lo} result of the op presented this cycle.
    // Divisor is forced to 1 for /0 and INT_MIN/-1 so the divider never traps.
    always_comb begin
        rt_zero = (E_RT == 32'd0);
        div_ovf = (E_RS == 32'h8000_0000) && (E_RT == 32'hFFFF_FFFF);
        rt_u    = rt_zero ? 32'd1 : E_RT;
        rs_s    = $signed(E_RS);
        rt_s    = (rt_zero || div_ovf) ? 32'sd1 : $signed(E_RT);
        prod_s  = {{32{E_RS[31]}}, E_RS} * {{32{E_RT[31]}}, E_RT};
        prod_u  = {32'd0, E_RS} * {32'd0, E_RT};
        quo_s   = div_ovf ? 32'sh8000_0000 : rs_s / rt_s;
        rem_s   = div_ovf ? 32'sd0 : rs_s % rt_s;
        quo_u   = E_RS / rt_u;
        rem_u   = E_RS % rt_u;
        res     = 64'd0;
        case (mdu_op_e'(E_MDUOp))
            MDU_MULT:  res = prod_s;
            MDU_MULTU: res = prod_u;
            MDU_DIV:   res = {rem_s, quo_s};
            MDU_DIVU:  res = {rem_u, quo_u};
            default:   res = 64'd0;
        endcase
    end

    // Next-state: start/latch, countdown, commit, and mthi/mtlo writes.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        sh_hi_d  = sh_hi_q;
        sh_lo_d  = sh_lo_q;
        commit_d = commit_q;
        unique case (state_q)
            MDU_IDLE: begin
                if (E_Start && mdu_is_start_op(E_MDUOp)) begin
                    state_d  = MDU_BUSY;
                    sh_hi_d  = res[63:32];
                    sh_lo_d  = res[31:0];
                    commit_d = !(mdu_is_div_op(E_MDUOp) && rt_zero);
                    cnt_d    = mdu_is_div_op(E_MDUOp) ? DIV_CNT : MULT_CNT;
                end else if (E_MDUOp == MDU_MTHI) begin
                    hi_d = E_RS;
                end else if (E_MDUOp == MDU_MTLO) begin
                    lo_d = E_RS;
                end
            end
            MDU_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 16'd1) begin
                    state_d = MDU_IDLE;
                    if (commit_q) begin
                        hi_d = sh_hi_q;
                        lo_d = sh_lo_q;
                    end
                end
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    // State registers with synchronous reset that aborts any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= MDU_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            sh_hi_q  <= '0;
            sh_lo_q  <= '0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            sh_hi_q  <= sh_hi_d;
            sh_lo_q  <= sh_lo_d;
            commit_q <= commit_d;
        end
    end

    // mfhi/mflo read of committed HI/LO onto the E-stage result path.
    always_comb begin
        E_MDUOut = 32'd0;
        if (E_MDUOp == MDU_MFHI) begin
            E_MDUOut = hi_q;
        end else if (E_MDUOp == MDU_MFLO) begin
            E_MDUOut = lo_q;
        end
    end

    assign E_Busy = (state_q == MDU_BUSY);
    assign E_HI   = hi_q;
    assign E_LO   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed self-checking bench for e_mdu.
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_e_mdu;
    import e_mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic [3:0]  E_MDUOp;
    logic        E_Start;
    logic [31:0] E_RS;
    logic [31:0] E_RT;
    logic        E_Busy;
    logic [31:0] E_MDUOut;
    logic [31:0] E_HI;
    logic [31:0] E_LO;

    int n_vec = 0;
    int n_err = 0;
    int illegal_starts = 0;

    e_mdu dut (
        .clk      (clk),
        .reset    (reset),
        .E_MDUOp  (E_MDUOp),
        .E_Start  (E_Start),
        .E_RS     (E_RS),
        .E_RT     (E_RT),
        .E_Busy   (E_Busy),
        .E_MDUOut (E_MDUOut),
        .E_HI     (E_HI),
        .E_LO     (E_LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol monitor: the hazard unit must never start while busy.
    always @(posedge clk) begin
        if (!reset && E_Start && E_Busy) begin
            illegal_starts++;
            $display("protocol note: E_Start while busy at %0t", $time);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish got timeout want finish");
        $fatal(1);
    end

    // Present a start for one cycle; returns in the first busy cycle.
    task automatic do_start(input logic [3:0] op,
                            input logic [31:0] rs,
                            input logic [31:0] rt);
        @(negedge clk);
        E_MDUOp = op;
        E_Start = 1'b1;
        E_RS    = rs;
        E_RT    = rt;
        @(negedge clk);
        E_Start = 1'b0;
        E_MDUOp = MDU_NONE;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        E_MDUOp = MDU_NONE;
        E_Start = 1'b0;
        E_RS = 32'd0;
        E_RT = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_vec++;
        if (E_Busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy got %b want 0", E_Busy);
        end
        n_vec++;
        if (E_HI !== 32'd0 || E_LO !== 32'd0) begin
            n_err++;
            $display("FAIL reset_hilo got %h/%h want 0/0", E_HI, E_LO);
        end
        E_MDUOp = MDU_MFHI;
        #1;
        n_vec++;
        if (E_MDUOut !== 32'd0) begin
            n_err++;
            $display("FAIL reset_mfhi got %h want 0", E_MDUOut);
        end
        E_MDUOp = MDU_NONE;
    endtask

    task automatic test_mult();
        do_start(MDU_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
        for (int k = 1; k <= MC; k++) begin
            n_vec++;
            if (E_Busy !== 1'b1 || E_HI !== 32'd0 || E_LO !== 32'd0) begin
                n_err++;
                $display("FAIL mult_busy k=%0d got busy=%b hi=%h lo=%h want 1/0/0",
                         k, E_Busy, E_HI, E_LO);
            end
            @(negedge clk);
        end
        n_vec++;
        if (E_Busy !== 1'b0 || E_HI !== 32'hFFFF_FFFF || E_LO !== 32'hFFFF_FFFE) begin
            n_err++;
            $display("FAIL mult_done got busy=%b hi=%h lo=%h want 0/ffffffff/fffffffe",
                     E_Busy, E_HI, E_LO);
        end
        E_MDUOp = MDU_MFHI;
        #1;
        n_vec++;
        if (E_MDUOut !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL mfhi got %h want ffffffff", E_MDUOut);
        end
        E_MDUOp = MDU_MFLO;
        #1;
        n_vec++;
        if (E_MDUOut !== 32'hFFFF_FFFE) begin
            n_err++;
            $display("FAIL mflo got %h want fffffffe", E_MDUOut);
        end
        E_MDUOp = MDU_NONE;
        #1;
        n_vec++;
        if (E_MDUOut !== 32'd0) begin
            n_err++;
            $display("FAIL mdu_out_none got %h want 0", E_MDUOut);
        end
    endtask

    task automatic test_multu();
        do_start(MDU_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        for (int k = 1; k <= MC; k++) begin
            n_vec++;
            if (E_Busy !== 1'b1 || E_HI !== 32'hFFFF_FFFF || E_LO !== 32'hFFFF_FFFE) begin
                n_err++;
                $display("FAIL multu_busy k=%0d got busy=%b hi=%h lo=%h want 1/ffffffff/fffffffe",
                         k, E_Busy, E_HI, E_LO);
            end
            @(negedge clk);
        end
        n_vec++;
        if (E_Busy !== 1'b0 || E_HI !== 32'h0000_0001 || E_LO !== 32'hFFFF_FFFE) begin
            n_err++;
            $display("FAIL multu_done got busy=%b hi=%h lo=%h want 0/00000001/fffffffe",
                     E_Busy, E_HI, E_LO);
        end
    endtask

    task automatic test_div();
        do_start(MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        for (int k = 1; k <= DC; k++) begin
            n_vec++;
            if (E_Busy !== 1'b1 || E_HI !== 32'h0000_0001) begin
                n_err++;
                $display("FAIL div_busy k=%0d got busy=%b hi=%h want 1/00000001",
                         k, E_Busy, E_HI);
            end
            @(negedge clk);
        end
        n_vec++;
        if (E_Busy !== 1'b0 || E_HI !== 32'hFFFF_FFFF || E_LO !== 32'hFFFF_FFFD) begin
            n_err++;
            $display("FAIL div_done got busy=%b hi=%h lo=%h want 0/ffffffff/fffffffd",
                     E_Busy, E_HI, E_LO);
        end
        do_start(MDU_DIVU, 32'd7, 32'd2);
        repeat (DC) @(negedge clk);
        n_vec++;
        if (E_Busy !== 1'b0 || E_HI !== 32'd1 || E_LO !== 32'd3) begin
            n_err++;
            $display("FAIL divu_done got busy=%b hi=%h lo=%h want 0/1/3",
                     E_Busy, E_HI, E_LO);
        end
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clk);
        E_MDUOp = MDU_MTHI;
        E_RS = 32'h1234_5678;
        @(negedge clk);
        n_vec++;
        if (E_HI !== 32'h1234_5678 || E_LO !== 32'd3) begin
            n_err++;
            $display("FAIL mthi got hi=%h lo=%h want 12345678/3", E_HI, E_LO);
        end
        E_MDUOp = MDU_MTLO;
        E_RS = 32'h9ABC_DEF0;
        @(negedge clk);
        n_vec++;
        if (E_HI !== 32'h1234_5678 || E_LO !== 32'h9ABC_DEF0) begin
            n_err++;
            $display("FAIL mtlo got hi=%h lo=%h want 12345678/9abcdef0", E_HI, E_LO);
        end
        E_MDUOp = MDU_NONE;
        do_start(MDU_DIV, 32'h0000_0055, 32'd0);
        for (int k = 1; k <= DC; k++) begin
            n_vec++;
            if (E_Busy !== 1'b1) begin
                n_err++;
                $display("FAIL div0_busy k=%0d got %b want 1", k, E_Busy);
            end
            if (k == 2) begin
                E_MDUOp = MDU_MTHI;
                E_RS = 32'hDEAD_BEEF;
            end else begin
                E_MDUOp = MDU_NONE;
            end
            @(negedge clk);
        end
        n_vec++;
        if (E_Busy !== 1'b0 || E_HI !== 32'h1234_5678 || E_LO !== 32'h9ABC_DEF0) begin
            n_err++;
            $display("FAIL div0_done got busy=%b hi=%h lo=%h want 0/12345678/9abcdef0",
                     E_Busy, E_HI, E_LO);
        end
    endtask

    task automatic test_div_ovf();
        do_start(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (DC) @(negedge clk);
        n_vec++;
        if (E_Busy !== 1'b0 || E_HI !== 32'd0 || E_LO !== 32'h8000_0000) begin
            n_err++;
            $display("FAIL div_ovf got busy=%b hi=%h lo=%h want 0/0/80000000",
                     E_Busy, E_HI, E_LO);
        end
        do_start(MDU_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (DC) @(negedge clk);
        n_vec++;
        if (E_HI !== 32'h8000_0000 || E_LO !== 32'd0) begin
            n_err++;
            $display("FAIL divu_big got hi=%h lo=%h want 80000000/0", E_HI, E_LO);
        end
    endtask

    task automatic test_back_to_back();
        do_start(MDU_DIV, 32'd100, 32'd7);
        for (int k = 1; k <= DC; k++) begin
            n_vec++;
            if (E_Busy !== 1'b1 || E_LO !== 32'd0) begin
                n_err++;
                $display("FAIL b2b_busy k=%0d got busy=%b lo=%h want 1/0",
                         k, E_Busy, E_LO);
            end
            if (k == 3) begin
                E_MDUOp = MDU_MULT;
                E_Start = 1'b1;
                E_RS = 32'd5;
                E_RT = 32'd6;
            end else begin
                E_MDUOp = MDU_NONE;
                E_Start = 1'b0;
            end
            @(negedge clk);
        end
        n_vec++;
        if (E_Busy !== 1'b0 || E_HI !== 32'd2 || E_LO !== 32'd14) begin
            n_err++;
            $display("FAIL b2b_done got busy=%b hi=%h lo=%h want 0/2/e",
                     E_Busy, E_HI, E_LO);
        end
        @(negedge clk);
        n_vec++;
        if (E_Busy !== 1'b0 || E_LO !== 32'd14) begin
            n_err++;
            $display("FAIL b2b_after got busy=%b lo=%h want 0/e", E_Busy, E_LO);
        end
        n_vec++;
        if (illegal_starts !== 1) begin
            n_err++;
            $display("FAIL b2b_monitor got %0d want 1", illegal_starts);
        end
    endtask

    task automatic test_reset_mid();
        do_start(MDU_MULT, 32'd3, 32'd4);
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (E_Busy !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_busy got %b want 1", E_Busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_vec++;
        if (E_Busy !== 1'b0 || E_HI !== 32'd0 || E_LO !== 32'd0) begin
            n_err++;
            $display("FAIL rstmid_abort got busy=%b hi=%h lo=%h want 0/0/0",
                     E_Busy, E_HI, E_LO);
        end
        repeat (4) @(negedge clk);
        n_vec++;
        if (E_Busy !== 1'b0 || E_HI !== 32'd0 || E_LO !== 32'd0) begin
            n_err++;
            $display("FAIL rstmid_nocommit got busy=%b hi=%h lo=%h want 0/0/0",
                     E_Busy, E_HI, E_LO);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_mthi_mtlo();
        test_div_ovf();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
Multiply/divide unit in the E stage, parallel to the ALU and the E-stage destination-register mux.
- Executes mult/multu/div/divu with fixed multi-cycle latency.
- Executes mthi/mtlo single-cycle writes.
- Supplies mfhi/mflo read data onto the E-stage result path that is written to E_A3 downstream.
- Exposes start/busy to the hazard unit so that D-stage MDU instructions stall while an operation is in flight.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1).
DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
E_MDUOp  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none.
E_Start  input  1  high for exactly one cycle when a mult/multu/div/divu instruction is in E.
E_RS  input  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo data).
E_RT  input  32  forwarded rt operand (divisor / multiplier).
E_Busy  output  1  operation in flight.
E_MDUOut  output  32  HI when op=7, LO when op=8, else 0.
E_HI  output  32  committed HI (debug/trace).
E_LO  output  32  committed LO (debug/trace).

Behaviour:
- Reset: HI=0, LO=0, E_Busy=0, counter=0, shadow result=0. Reset wins over every other input in the same cycle.
- Reset mid-operation: the operation is aborted and nothing is committed.
- States:
  - IDLE (E_Busy=0).
  - BUSY (E_Busy=1, counter counts down).
- IDLE -> BUSY on an edge where E_Start=1 and op is in 1..4:
  - E_RS/E_RT latched.
  - Full 64-bit result computed into the shadow {hi,lo}.
  - counter loaded with MULT_CYCLES or DIV_CYCLES.
- BUSY: counter decrements each edge. On the edge where the counter = 1:
  - the shadow is copied to HI/LO.
  - E_Busy falls, i.e. the state returns to IDLE.
- Timing for start sampled at edge t0:
  - E_Busy is high for exactly N cycles after t0.
  - The new HI/LO are visible in the first cycle with E_Busy=0.
- E_Start with op outside 1..4, or E_Start while BUSY: ignored. The hazard unit guarantees the latter never occurs; the bench flags it.
- mthi/mtlo:
  - Op 5/6 in IDLE writes E_RS to HI/LO at the next edge.
  - Ignored in BUSY.
  - E_Start is not required.
- mfhi/mflo: combinational read of committed HI/LO. During BUSY it returns the old value; the stall unit prevents this case.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI = bits 63:32, LO = bits 31:0.
  - multu: unsigned, same split.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - Divisor 0 (div/divu): full busy period still taken, HI/LO left unchanged at the end.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Stall interface: the hazard unit stalls D when (E_Start | E_Busy) and the D-stage instruction is an MDU op. This block only provides E_Busy; E_Start is already visible upstream.

Decomposition:
- Shared package/header holds:
  - MDU op codes: MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO, MDU_MFHI, MDU_MFLO.
  - Default cycle counts.
  - The D-stage decoder and hazard unit reuse the same codes.
- No sub-module is required. The arithmetic is a single combinational block feeding the shadow register, so no separate counter module is needed.

Test Plan:
1. mult, RS=0xFFFFFFFF, RT=0x00000002, start at t0 -> E_Busy high for cycles t0+1..t0+5; at t0+6 HI=0xFFFFFFFF, LO=0xFFFFFFFE; mfhi returns 0xFFFFFFFF.
2. multu, same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles; HI/LO hold old values during busy.
3. div RS=-7 (0xFFFFFFF9), RT=2 -> 10 busy cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu RS=7, RT=2 -> LO=3, HI=1.
4. mthi 0x12345678, then mtlo 0x9ABCDEF0 in IDLE -> HI/LO updated on the following edges. Then div by RT=0 -> 10 busy cycles, HI/LO unchanged.
5. mult started, reset asserted in the 3rd busy cycle -> next cycle E_Busy=0, HI=LO=0, and no commit occurs when the original completion time passes.
6. E_Start with op=mult while busy from a previous div -> ignored; div result commits at its scheduled cycle; the bench assertion fires.
